// File: rtl/spike_encoder_seq_if.sv
// Pixel-image handshake between an image source (master) and spike_encoder_seq (slave).
interface spike_encoder_seq_if #(
  parameter int NUM_SPIKES = 16,
  parameter int PIX_BITS   = 8
);
  logic                           pix_valid;
  logic                           pix_ready;
  logic [NUM_SPIKES*PIX_BITS-1:0] pix_data;
  logic                           train_in;

  modport master (output pix_valid, output pix_data, output train_in, input pix_ready);
  modport slave  (input pix_valid, input pix_data, input train_in, output pix_ready);
endinterface

// File: rtl/spike_encoder_seq.sv
// Rate-to-latency spike encoder: latches an image, then plays out one timed frame.
// Optional one-image prefetch buffer enabled by defining ENCODER_PREFETCH_EN.
module spike_encoder_seq #(
  parameter int NUM_SPIKES = 16,
  parameter int PIX_BITS   = 8,
  parameter int LOG_TP     = 3,
  parameter int LOG_TIME   = 4,
  parameter int THRESH     = 64
) (
  input  logic                                 clk,
  input  logic                                 rst,
  spike_encoder_seq_if.slave                   pix,
  output logic [LOG_TIME:0]                    time_val,
  output logic [NUM_SPIKES*(LOG_TP+1)-1:0]     spike_times,
  output logic                                 training,
  output logic                                 busy,
  output logic                                 frame_done
);

  localparam int FW = LOG_TP + 1;
  localparam int SW = NUM_SPIKES * FW;
  localparam logic [PIX_BITS:0] LP_THRESH     = (PIX_BITS+1)'(THRESH);
  localparam logic [LOG_TIME:0] LP_LAST_TEST  = (LOG_TIME+1)'((2**LOG_TP) - 1);
  localparam logic [LOG_TIME:0] LP_LAST_TRAIN = (LOG_TIME+1)'((2**LOG_TP) + NUM_SPIKES - 1);
  localparam logic [SW-1:0]     LP_SUPP       = {SW{1'b1}};

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  state_t            r_state;
  logic [SW-1:0]     r_spk;
  logic [LOG_TIME:0] r_time;
  logic              r_train;
  logic              r_busy;
  logic              r_done;
  logic              r_ready;
`ifdef ENCODER_PREFETCH_EN
  logic [SW-1:0]     r_buf_spk;
  logic              r_buf_train;
  logic              r_buf_full;
`endif

  logic [SW-1:0]     w_enc;
  logic              w_accept;
  logic [LOG_TIME:0] w_last_time;
  logic [LOG_TIME:0] w_time_inc;
  logic              w_at_last;

  // Dim pixels are suppressed; otherwise the top LOG_TP bits of the inverted intensity give the spike time.
  function automatic logic [FW-1:0] encode_pix(input logic [PIX_BITS-1:0] p);
    logic [PIX_BITS-1:0] inv;
    inv = ~p;
    if ({1'b0, p} < LP_THRESH) begin
      encode_pix = {FW{1'b1}};
    end else begin
      encode_pix = {1'b0, inv[PIX_BITS-1 -: LOG_TP]};
    end
  endfunction

  function automatic logic [SW-1:0] encode_img(input logic [NUM_SPIKES*PIX_BITS-1:0] d);
    logic [SW-1:0] res;
    res = LP_SUPP;
    for (int i = 0; i < NUM_SPIKES; i++) begin
      res[i*FW +: FW] = encode_pix(d[i*PIX_BITS +: PIX_BITS]);
    end
    return res;
  endfunction

  // Encoded image, handshake and end-of-frame detection.
  always_comb begin
    w_enc       = encode_img(pix.pix_data);
    w_accept    = pix.pix_valid & r_ready;
    w_last_time = r_train ? LP_LAST_TRAIN : LP_LAST_TEST;
    w_time_inc  = r_time + {{LOG_TIME{1'b0}}, 1'b1};
    w_at_last   = (r_time == w_last_time);
  end

  // Frame sequencer with registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_spk   <= LP_SUPP;
      r_time  <= '0;
      r_train <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_ready <= 1'b0;
`ifdef ENCODER_PREFETCH_EN
      r_buf_spk   <= LP_SUPP;
      r_buf_train <= 1'b0;
      r_buf_full  <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          r_ready <= 1'b1;
          if (w_accept) begin
            r_state <= S_RUN;
            r_spk   <= w_enc;
            r_train <= pix.train_in;
            r_time  <= '0;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
`ifdef ENCODER_PREFETCH_EN
            r_ready <= 1'b1;
`else
            r_ready <= 1'b0;
`endif
          end
        end
        S_RUN: begin
          if (w_at_last) begin
            r_time <= '0;
            r_done <= 1'b0;
`ifdef ENCODER_PREFETCH_EN
            r_ready <= 1'b1;
            if (r_buf_full) begin
              r_spk      <= r_buf_spk;
              r_train    <= r_buf_train;
              r_buf_full <= 1'b0;
            end else if (w_accept) begin
              r_spk   <= w_enc;
              r_train <= pix.train_in;
            end else begin
              r_state <= S_IDLE;
              r_spk   <= LP_SUPP;
              r_busy  <= 1'b0;
            end
`else
            r_state <= S_IDLE;
            r_spk   <= LP_SUPP;
            r_busy  <= 1'b0;
            r_ready <= 1'b1;
`endif
          end else begin
            r_time <= w_time_inc;
            r_done <= (w_time_inc == w_last_time);
`ifdef ENCODER_PREFETCH_EN
            // Image offered mid-frame is parked until the current frame ends.
            if (w_accept) begin
              r_buf_spk   <= w_enc;
              r_buf_train <= pix.train_in;
              r_buf_full  <= 1'b1;
              r_ready     <= 1'b0;
            end
`endif
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_spk   <= LP_SUPP;
          r_time  <= '0;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_ready <= 1'b0;
        end
      endcase
    end
  end

  assign pix.pix_ready = r_ready;
  assign time_val      = r_time;
  assign spike_times   = r_spk;
  assign training      = r_train;
  assign busy          = r_busy;
  assign frame_done    = r_done;

endmodule

// File: tb/tb_spike_encoder_seq.sv
// Directed self-checking bench for spike_encoder_seq; inputs driven and outputs sampled on falling edges.
module tb_spike_encoder_seq;
  localparam int NS  = 16;
  localparam int PB  = 8;
  localparam int LTP = 3;
  localparam int LT  = 4;
`ifdef ENCODER_PREFETCH_EN
  localparam logic PF = 1'b1;
`else
  localparam logic PF = 1'b0;
`endif

  localparam logic [NS*PB-1:0]      IMG_A = 128'h3F4080FF;
  localparam logic [63:0]           EXP_A = 64'hFFFF_FFFF_FFFF_F530;
  localparam logic [NS*PB-1:0]      IMG_B = 128'h64C8;
  localparam logic [63:0]           EXP_B = 64'hFFFF_FFFF_FFFF_FF41;
  localparam logic [63:0]           SUPP  = 64'hFFFF_FFFF_FFFF_FFFF;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  spike_encoder_seq_if #(.NUM_SPIKES(NS), .PIX_BITS(PB)) pix_if ();

  logic [LT:0]          time_val;
  logic [NS*(LTP+1)-1:0] spike_times;
  logic                 training;
  logic                 busy;
  logic                 frame_done;

  spike_encoder_seq dut (
    .clk         (clk),
    .rst         (rst),
    .pix         (pix_if),
    .time_val    (time_val),
    .spike_times (spike_times),
    .training    (training),
    .busy        (busy),
    .frame_done  (frame_done)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic check_idle(input string tag);
    check_val({tag, "_busy"}, 64'(busy), 64'd0);
    check_val({tag, "_time"}, 64'(time_val), 64'd0);
    check_val({tag, "_spk"}, 64'(spike_times), SUPP);
    check_val({tag, "_done"}, 64'(frame_done), 64'd0);
    check_val({tag, "_ready"}, 64'(pix_if.pix_ready), 64'd1);
  endtask

  // Offer one image, then check every frame cycle and the idle cycle after it.
  task automatic run_frame(input logic [NS*PB-1:0] img, input logic trn,
                           input logic [63:0] exp_spk, input int len);
    @(negedge clk);
    check_val("pre_ready", 64'(pix_if.pix_ready), 64'd1);
    pix_if.pix_valid = 1'b1;
    pix_if.pix_data  = img;
    pix_if.train_in  = trn;
    @(negedge clk);
    pix_if.pix_valid = 1'b0;
    pix_if.pix_data  = '0;
    for (int t = 0; t < len; t++) begin
      check_val("time_val", 64'(time_val), 64'(t));
      check_val("busy", 64'(busy), 64'd1);
      check_val("spike_times", 64'(spike_times), exp_spk);
      check_val("training", 64'(training), 64'(trn));
      check_val("frame_done", 64'(frame_done), 64'(t == len - 1));
      check_val("run_ready", 64'(pix_if.pix_ready), 64'(PF));
      if (t == 4) pix_if.train_in = ~trn;
      @(negedge clk);
    end
    check_idle("post");
  endtask

  initial begin
    pix_if.pix_valid = 1'b0;
    pix_if.pix_data  = '0;
    pix_if.train_in  = 1'b0;
    #12;
    check_val("rst_ready", 64'(pix_if.pix_ready), 64'd0);
    check_val("rst_busy", 64'(busy), 64'd0);
    check_val("rst_time", 64'(time_val), 64'd0);
    check_val("rst_spk", 64'(spike_times), SUPP);
    check_val("rst_train", 64'(training), 64'd0);
    check_val("rst_done", 64'(frame_done), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_idle("rel");

    run_frame(IMG_A, 1'b0, EXP_A, 8);
    run_frame(IMG_B, 1'b1, EXP_B, 24);

`ifdef ENCODER_PREFETCH_EN
    @(negedge clk);
    pix_if.pix_valid = 1'b1;
    pix_if.pix_data  = IMG_A;
    pix_if.train_in  = 1'b0;
    @(negedge clk);
    pix_if.pix_valid = 1'b0;
    for (int t = 0; t < 8; t++) begin
      check_val("pf_time", 64'(time_val), 64'(t));
      check_val("pf_spk", 64'(spike_times), EXP_A);
      check_val("pf_done", 64'(frame_done), 64'(t == 7));
      if (t == 3) begin
        check_val("pf_ready_empty", 64'(pix_if.pix_ready), 64'd1);
        pix_if.pix_valid = 1'b1;
        pix_if.pix_data  = IMG_B;
      end
      if (t == 4) begin
        check_val("pf_ready_full", 64'(pix_if.pix_ready), 64'd0);
        pix_if.pix_valid = 1'b0;
        pix_if.pix_data  = '0;
      end
      @(negedge clk);
    end
    check_val("pf2_time", 64'(time_val), 64'd0);
    check_val("pf2_busy", 64'(busy), 64'd1);
    check_val("pf2_spk", 64'(spike_times), EXP_B);
    check_val("pf2_ready", 64'(pix_if.pix_ready), 64'd1);
    repeat (8) @(negedge clk);
    check_idle("pf_end");
`else
    @(negedge clk);
    pix_if.pix_valid = 1'b1;
    pix_if.pix_data  = IMG_A;
    pix_if.train_in  = 1'b0;
    @(negedge clk);
    for (int t = 0; t < 8; t++) begin
      check_val("cv_time", 64'(time_val), 64'(t));
      check_val("cv_ready", 64'(pix_if.pix_ready), 64'd0);
      check_val("cv_busy", 64'(busy), 64'd1);
      @(negedge clk);
    end
    check_idle("cv_gap");
    @(negedge clk);
    check_val("cv2_busy", 64'(busy), 64'd1);
    check_val("cv2_time", 64'(time_val), 64'd0);
    check_val("cv2_ready", 64'(pix_if.pix_ready), 64'd0);
    pix_if.pix_valid = 1'b0;
    repeat (8) @(negedge clk);
    check_idle("cv_end");
`endif

    // Mid-frame asynchronous reset on a training frame.
    @(negedge clk);
    pix_if.pix_valid = 1'b1;
    pix_if.pix_data  = IMG_B;
    pix_if.train_in  = 1'b1;
    @(negedge clk);
    pix_if.pix_valid = 1'b0;
    repeat (5) @(negedge clk);
    check_val("ar_time_pre", 64'(time_val), 64'd5);
    check_val("ar_train_pre", 64'(training), 64'd1);
    #2 rst = 1'b1;
    #1;
    check_val("ar_time", 64'(time_val), 64'd0);
    check_val("ar_busy", 64'(busy), 64'd0);
    check_val("ar_spk", 64'(spike_times), SUPP);
    check_val("ar_train", 64'(training), 64'd0);
    check_val("ar_ready", 64'(pix_if.pix_ready), 64'd0);
    check_val("ar_done", 64'(frame_done), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_idle("ar_rel");
    repeat (20) begin
      @(negedge clk);
      check_val("ar_no_done", 64'(frame_done), 64'd0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/spike_encoder_seq.md
SPIKE_ENCODER_SEQ -- requirements
Module: spike_encoder_seq

Interface
REQ-001 SHALL have parameter NUM_SPIKES, default 16: number of input pixels/spike channels.
REQ-002 SHALL have parameter PIX_BITS, default 8: pixel intensity width.
REQ-003 SHALL have parameter LOG_TP, default 3: testing period is 2^LOG_TP = 8 cycles.
REQ-004 SHALL have parameter LOG_TIME, default 4: time_val width is LOG_TIME+1 bits.
REQ-005 SHALL have parameter THRESH, default 64: pixels below THRESH produce no spike.
REQ-006 SHALL have the following ports, one per line; the clock and reset are fixed: one clock, with reset asynchronous and active-high.
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- pix_valid  in  1  image present on pix_data.
- pix_ready  out  1  encoder accepts an image this cycle.
- pix_data  in  NUM_SPIKES x PIX_BITS  image, channel i = pixel i.
- train_in  in  1  training flag for the offered image.
- time_val  out  LOG_TIME+1  frame time counter feeding layer.
- spike_times  out  NUM_SPIKES x (LOG_TP+1)  per channel: MSB = no-spike flag (1 = suppressed), low LOG_TP bits = spike time.
- training  out  1  training flag of the frame in progress.
- busy  out  1  frame in progress.
- frame_done  out  1  one-cycle pulse on the last cycle of a frame.

Function
REQ-007 SHALL transfer an image only on a rising clk edge with pix_valid=1 and pix_ready=1; train_in is captured with the image.
REQ-008 SHALL encode each pixel p: if p < THRESH, the field is {1, all ones}; otherwise the field is {0, (2^PIX_BITS-1-p) >> (PIX_BITS-LOG_TP)}; brighter pixels spike earlier.
REQ-009 SHALL register the encoded fields at accept time, never combinationally from pix_data.
REQ-010 SHALL implement states IDLE and RUN.
REQ-011 In IDLE: pix_ready=1, busy=0, time_val=0, all spike_times fields={1, all ones}.
REQ-012 SHALL move IDLE->RUN on accept; the first RUN cycle is the next cycle, with time_val=0 and spike_times driven from the encoded image.
REQ-013 In RUN: time_val increments by 1 per cycle, busy=1, and spike_times and training are held constant.
REQ-014 SHALL define frame length L = 2^LOG_TP + NUM_SPIKES (24) when training=1, else 2^LOG_TP (8); the last frame cycle is time_val=L-1.
REQ-015 SHALL assert frame_done on the last frame cycle only.
REQ-016 After the last cycle, SHALL return to IDLE unless a next image is pending (REQ-023), in which case the next cycle starts a new frame with time_val=0.
REQ-017 SHALL ignore changes to train_in during RUN; training changes only at frame start.
REQ-018 SHALL never let time_val exceed L-1 and SHALL never wrap it within a frame.
REQ-019 SHALL treat pix_valid dropping without an accept as no transfer.

Reset
REQ-020 While rst=1, regardless of clk: state=IDLE, time_val=0, all spike_times fields={1, all ones}, training=0, busy=0, frame_done=0, pix_ready=0, prefetch buffer empty.
REQ-021 SHALL take pix_ready to 1 on the first clk edge after rst deasserts.
REQ-022 Reset mid-frame SHALL abort the frame with no frame_done and discard any pending image.

Configuration
REQ-023 With ENCODER_PREFETCH_EN defined, SHALL include a one-image prefetch buffer:
- pix_ready=1 in RUN while the buffer is empty; an accept in RUN fills it.
- On the last frame cycle with the buffer full, the next cycle starts the buffered frame, with zero idle cycles, and the buffer empties.
- An accept on the last frame cycle with the buffer empty SHALL also start the next frame back-to-back.
REQ-024 Without ENCODER_PREFETCH_EN, SHALL include no buffer, SHALL hold pix_ready=0 throughout RUN, and SHALL spend at least one IDLE cycle between frames.

Verification
REQ-025 Test image with train_in=0, pixels 255, 128, 64, 63 (rest 0) -> fields {0,0}, {0,3}, {0,5}, {1,7}, rest {1,7}; time_val runs 0..7; frame_done pulses at time_val=7.
REQ-026 Training image (train_in=1) -> time_val runs 0..23; frame_done pulses at 23; training=1 throughout; train_in toggled mid-frame has no effect.
REQ-027 ENCODER_PREFETCH_EN defined, second image offered at time_val=3 -> accepted at once; its frame starts with time_val=0 on the cycle after frame_done, busy stays 1.
REQ-028 Macro undefined, pix_valid held high continuously -> pix_ready=0 during RUN; exactly one IDLE cycle with time_val=0 between frames.
REQ-029 rst pulsed at time_val=5 -> outputs reach reset values immediately without waiting for clk; no frame_done; pix_ready=1 one edge after release.
